mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage_pkg.sv | 14 +
 rtl/mem_wb_stage_ram.sv | 25 ++
 rtl/mem_wb_stage.sv | 96 +++++++++
 tb/tb_mem_wb_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared types and constants for the memory/writeback stage
package mem_wb_stage_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_wb_stage_ram.sv
// rtl/mem_wb_stage_ram.sv - data RAM with synchronous write and registered read
module data_ram
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // No reset: contents survive a stage reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - load/store/pass-through stage feeding register writeback
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_is_load,
  input  logic                 in_is_store,
  input  logic [DATA_W-1:0]    in_addr,
  input  logic [DATA_W-1:0]    in_wdata,
  input  logic [REG_IDX_W-1:0] in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_we,
  output logic                 misalign_err
);

  localparam int AW = $clog2(DEPTH);

  state_t            state, state_next;
  logic              accept, is_load, is_store, is_mem, aligned;
  logic              ram_we, ram_re;
  logic [AW-1:0]     word_idx;
  logic [DATA_W-1:0] ram_rdata;
  logic              we_q;

  assign in_ready = rst && ((state == ST_IDLE) || ((state == ST_OUT) && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_load  = in_is_load;
  // A load with the store bit also set wins; the store is dropped.
  assign is_store = in_is_store && !in_is_load;
  assign is_mem   = is_load || is_store;
  assign aligned  = (in_addr[1:0] == 2'b00);
  assign word_idx = in_addr[AW+1:2];
  assign ram_we   = accept && is_store && aligned;
  assign ram_re   = accept && is_load && aligned;

  data_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (word_idx),
    .wdata (in_wdata),
    .re    (ram_re),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_OUT: begin
        if (accept) begin
          if (!is_mem)          state_next = ST_OUT;
          else if (ram_re)      state_next = ST_RD;
          else                  state_next = ST_IDLE;
        end else if (state == ST_OUT && out_ready) begin
          state_next = ST_IDLE;
        end
      end
      ST_RD:   state_next = ST_OUT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      out_rd       <= '0;
      out_data     <= '0;
      we_q         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      misalign_err <= accept && is_mem && !aligned;
      if (accept && !is_mem) begin
        out_rd   <= in_rd;
        out_data <= in_addr;
        we_q     <= (in_rd != ZERO_REG);
      end else if (ram_re) begin
        out_rd <= in_rd;
        we_q   <= (in_rd != ZERO_REG);
      end
      if (state == ST_RD) out_data <= ram_rdata;
    end
  end

  assign out_valid = (state == ST_OUT);
  assign out_we    = out_valid && we_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready, out_we, misalign_err;
  logic [4:0]  out_rd;
  logic [31:0] out_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DEPTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_load   (in_is_load),
    .in_is_store  (in_is_store),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd        (in_rd),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .out_we       (out_we),
    .misalign_err (misalign_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    in_valid = v; in_is_load = ld; in_is_store = st;
    in_addr = a; in_wdata = wd; in_rd = rd;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b0; out_ready = 1'b1; idle_in();
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || out_we !== 1'b0 || out_rd !== 5'd0 || out_data !== 32'h0 || misalign_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b we=%b rd=%0d data=%h err=%b, expected all zero",
               out_valid, out_we, out_rd, out_data, misalign_err);
    end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    rst = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_store_load();
    drive(1'b1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF, 5'd0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL store_no_output: valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd9);
    tick();
    idle_in();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL load_rd_state: valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_rd !== 5'd9 || out_we !== 1'b1) begin
      failures++;
      $display("FAIL load_result: valid=%b data=%h rd=%0d we=%b expected 1/deadbeef/9/1",
               out_valid, out_data, out_rd, out_we);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_idle: valid=%b expected 0", out_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h11223344, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd4);
    tick(); idle_in(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11223344 || out_rd !== 5'd4) begin
      failures++; $display("FAIL wrap_load: valid=%b data=%h rd=%0d expected 1/11223344/4", out_valid, out_data, out_rd);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd7);
    tick();
    drive(1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 5'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_rd !== 5'd7 || out_we !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%h rd=%0d we=%b ready=%b expected 1/deadbeef/7/1/0",
                 i, out_valid, out_data, out_rd, out_we, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h5A, 32'h0, 5'd3);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_accept_ready: got %b expected 1", in_ready); end
    tick();
    idle_in();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h5A || out_rd !== 5'd3 || out_we !== 1'b1) begin
      failures++;
      $display("FAIL no_bubble: valid=%b data=%h rd=%0d we=%b expected 1/5a/3/1", out_valid, out_data, out_rd, out_we);
    end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 1'b0, 32'h6, 32'h0, 5'd5);
    tick();
    idle_in();
    checks++;
    if (misalign_err !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL misalign_pulse: err=%b valid=%b ready=%b expected 1/0/1", misalign_err, out_valid, in_ready);
    end
    tick();
    checks++;
    if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL misalign_end: err=%b valid=%b expected 0/0", misalign_err, out_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h9, 32'h00000BAD, 5'd0);
    tick();
    checks++;
    if (misalign_err !== 1'b1) begin failures++; $display("FAIL misalign_store: err=%b expected 1", misalign_err); end
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd6);
    tick(); idle_in(); tick();
    checks++;
    if (out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL misalign_store_suppressed: data=%h expected deadbeef", out_data);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd0);
    tick();
    idle_in();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || out_we !== 1'b0) begin
      failures++; $display("FAIL zero_reg: valid=%b data=%h we=%b expected 1/77/0", out_valid, out_data, out_we);
    end
    tick();
  endtask

  task automatic test_load_store_both();
    drive(1'b1, 1'b1, 1'b1, 32'h8, 32'h0000CAFE, 5'd2);
    tick(); idle_in(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_rd !== 5'd2) begin
      failures++; $display("FAIL both_as_load: valid=%b data=%h rd=%0d expected 1/deadbeef/2", out_valid, out_data, out_rd);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd2);
    tick(); idle_in(); tick();
    checks++;
    if (out_data !== 32'hDEADBEEF) begin
      failures++; $display("FAIL both_store_suppressed: data=%h expected deadbeef", out_data);
    end
    tick();
  endtask

  task automatic test_reset_in_rd();
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd9);
    tick();
    idle_in();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== 32'h0) begin
      failures++; $display("FAIL reset_in_rd: valid=%b ready=%b data=%h expected 0/0/0", out_valid, in_ready, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_discard: valid=%b expected 0", out_valid); end
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 5'd9);
    tick(); idle_in(); tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_rd !== 5'd9) begin
      failures++; $display("FAIL ram_survives_reset: valid=%b data=%h rd=%0d expected 1/deadbeef/9", out_valid, out_data, out_rd);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_backpressure();
    test_misaligned();
    test_zero_reg();
    test_load_store_both();
    test_reset_in_rd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
